// File: rtl/mmio_uart_tx_if.sv
// Bus-side handshake of the memory-mapped UART transmitter.
// The core drives requests through master and the peripheral answers through slave.
`timescale 1ns/1ps
interface mmio_uart_tx_if;
  logic        req_i;
  logic        we_i;
  logic [3:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o;

  modport master (output req_i, we_i, addr_i, wdata_i, input rdata_o, ack_o);
  modport slave  (input req_i, we_i, addr_i, wdata_i, output rdata_o, ack_o);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter.
// Core stores feed a small TX FIFO, and a serial engine drains that FIFO onto tx_o.
`timescale 1ns/1ps
module mmio_uart_tx #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mmio_uart_tx_if.slave bus,
  output logic          tx_o
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [AW:0]   DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST  = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] cyc_cnt, cyc_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shift, shift_n;
  logic          tx_d, ovf, pop, push, push_ok, full, empty, busy, bit_end;
  logic          wr, rd, ack_q;
  logic [31:0]   rdata_q;
  logic          wdata_unused;

  assign wr           = bus.req_i & bus.we_i;
  assign rd           = bus.req_i & ~bus.we_i;
  assign push         = wr && (bus.addr_i == 4'h0);
  assign full         = (count == DEPTH);
  assign empty        = (count == '0);
  assign busy         = (state != IDLE);
  assign push_ok      = push && (!full || pop);
  assign bit_end      = (cyc_cnt == LAST);
  assign wdata_unused = ^bus.wdata_i[31:8];

  assign bus.ack_o   = ack_q;
  assign bus.rdata_o = rdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= bus.req_i;
      rdata_q <= (rd && bus.addr_i == 4'h4) ? {28'b0, ovf, busy, empty, full} : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= bus.wdata_i[7:0];
  end

  // A push against a full FIFO is still taken when the engine pops in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !push_ok)                                ovf <= 1'b1;
      else if (wr && bus.addr_i == 4'h8 && bus.wdata_i[0]) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      tx_o    <= 1'b1;
    end else begin
      state   <= state_n;
      cyc_cnt <= cyc_n;
      bit_cnt <= bit_n;
      shift   <= shift_n;
      tx_o    <= tx_d;
    end
  end

  always_comb begin
    state_n = state;
    cyc_n   = cyc_cnt;
    bit_n   = bit_cnt;
    shift_n = shift;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = START;
          cyc_n   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          bit_n   = '0;
          cyc_n   = '0;
        end else begin
          cyc_n = cyc_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cyc_n   = '0;
          shift_n = shift >> 1;
          if (bit_cnt == 3'd7) state_n = STOP;
          else                 bit_n   = bit_cnt + 1'b1;
        end else begin
          cyc_n = cyc_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cyc_n = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cyc_n = cyc_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The line level is computed from the next state so that tx_o itself is a register.
  always_comb begin
    case (state_n)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_n[0];
      default: tx_d = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed and randomized checks of mmio_uart_tx against a frame-level line model.
// The model derives every tx_o sample from the list of bytes expected on the wire.
`timescale 1ns/1ps
module tb_mmio_uart_tx;
  localparam int CD    = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus),
    .tx_o  (tx)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         t0       = 0;
  logic [7:0] stream[$];
  logic [7:0] bq[$];

  // Expected line level k cycles after the first start bit of a contiguous stream.
  function automatic logic exp_tx(int k);
    int f, p;
    if (k < 0 || k >= stream.size() * FRAME) return 1'b1;
    f = k / FRAME;
    p = (k % FRAME) / CD;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return stream[f][p-1];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic w, input logic [3:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd);
    @(negedge clk);
    bus.req_i   = r;
    bus.we_i    = w;
    bus.addr_i  = a;
    bus.wdata_i = d;
    @(posedge clk);
    #1;
    cyc++;
    chk("tx", {31'b0, tx}, {31'b0, exp_tx(cyc - t0)});
    chk("ack", {31'b0, bus.ack_o}, {31'b0, r});
    chk("rdata", bus.rdata_o, (r && !w) ? exp_rd : 32'h0);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic status(input logic [31:0] exp);
    cycle(1'b1, 1'b0, 4'h4, 32'h0, exp);
  endtask

  // Consecutive TXDATA writes starting from an idle line. The first byte leaves the
  // FIFO right away, so DEPTH+1 bytes fit and any later bytes are dropped.
  task automatic burst(input logic [7:0] b[$]);
    for (int i = 0; i < b.size(); i++) begin
      cycle(1'b1, 1'b1, 4'h0, {24'h0, b[i]}, 32'h0);
      if (i == 0) begin
        stream.delete();
        t0 = cyc + 1;
      end
      if (i <= DEPTH) stream.push_back(b[i]);
    end
  endtask

  task automatic drain();
    while (cyc - t0 < stream.size() * FRAME + 3) idle();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
    bus.addr_i  = 4'h0;
    bus.wdata_i = 32'h0;

    // Reset asserted and released away from the clock edge.
    #13 rst = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("reset_tx", {31'b0, tx}, 32'h1);
    chk("reset_ack", {31'b0, bus.ack_o}, 32'h0);
    chk("reset_rdata", bus.rdata_o, 32'h0);
    @(negedge clk) rst = 1'b0;
    idle();
    status(32'h2);

    // Single byte, with a mid-frame STATUS read.
    bq.delete(); bq.push_back(8'hA5);
    burst(bq);
    repeat (5) idle();
    status(32'h6);
    drain();
    status(32'h2);

    // Back-to-back writes form contiguous frames.
    bq.delete(); bq.push_back(8'h41); bq.push_back(8'h42); bq.push_back(8'h43);
    burst(bq);
    drain();
    status(32'h2);

    // Overflow: ten writes while the first frame is on the wire.
    bq.delete();
    for (int i = 0; i < 10; i++) bq.push_back(8'($urandom));
    burst(bq);
    status(32'hD);
    cycle(1'b1, 1'b1, 4'h8, 32'h0, 32'h0);
    status(32'hD);
    cycle(1'b1, 1'b1, 4'h8, 32'h1, 32'h0);
    status(32'h5);
    drain();
    status(32'h2);

    // Decode of non-STATUS offsets.
    cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle(1'b1, 1'b0, 4'h8, 32'h0, 32'h0);
    cycle(1'b1, 1'b0, 4'hC, 32'h0, 32'h0);
    cycle(1'b1, 1'b1, 4'hC, 32'hFF, 32'h0);
    repeat (3) idle();
    status(32'h2);

    // Randomized bursts, which sometimes overflow.
    repeat (6) begin
      n = int'($urandom_range(1, 12));
      bq.delete();
      for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
      burst(bq);
      drain();
      status((n > DEPTH + 1) ? 32'hA : 32'h2);
      cycle(1'b1, 1'b1, 4'h8, 32'h1, 32'h0);
      status(32'h2);
    end

    // Reset during DATA with three bytes still queued.
    bq.delete(); bq.push_back(8'h00); bq.push_back(8'h11); bq.push_back(8'h22); bq.push_back(8'h33);
    burst(bq);
    repeat (8) idle();
    chk("pre_reset_tx_low", {31'b0, tx}, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("midframe_reset_tx", {31'b0, tx}, 32'h1);
    stream.delete();
    @(negedge clk) rst = 1'b0;
    repeat (2 * FRAME) idle();
    status(32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the core's data bus, downstream of the core's load/store path. Core stores push bytes into a small TX FIFO. A serial engine drains the FIFO as 8N1 frames on tx_o. This gives programs a console output path visible in the simulation waveforms and on hardware.

Parameters:
CLK_DIV, 16, clock cycles per serial bit (>=2)
FIFO_DEPTH, 8, TX FIFO entries; power of two, >=2

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset
req_i  in  1  bus request, one-cycle pulse
we_i  in  1  1=write, 0=read
addr_i  in  4  byte offset within peripheral
wdata_i  in  32  write data
rdata_o  out  32  read data, valid with ack_o
ack_o  out  1  bus acknowledge
tx_o  out  1  serial output, idle high

Behaviour:
- Reset: one clock (clk_i), reset rst_i asynchronous active-high. Reset values: tx_o=1, ack_o=0, rdata_o=0, FIFO empty (count=0, pointers 0), ovf=0, FSM=IDLE, bit/cycle counters 0.
- Reset mid-frame: tx_o returns to 1 immediately; queued bytes are discarded.
- Bus handshake: a request is sampled at rising edge N when req_i=1. ack_o=1 for exactly the cycle after edge N. Back-to-back requests are each acked one cycle later. rdata_o is registered and valid only while ack_o=1; it is 0 otherwise and 0 for writes.
- Register map:
  - 0x0 TXDATA: write pushes wdata_i[7:0]; read returns 0.
  - 0x4 STATUS (read-only): {28'b0, ovf, busy, empty, full}. Value reflects state just before edge N.
  - 0x8 CTRL: write with wdata_i[0]=1 clears ovf; read returns 0.
  - Any other offset: write ignored, read returns 0.
- FIFO: count ranges 0..FIFO_DEPTH. full = (count==FIFO_DEPTH); empty = (count==0).
  - Push while full with no pop in the same cycle: byte dropped, ovf<=1 (sticky).
  - Push and pop in the same cycle: both take effect; count unchanged. This also applies when full, in which case the push is accepted.
  - Pointers wrap modulo FIFO_DEPTH.
- TX FSM states: IDLE, START, DATA, STOP. Each bit lasts exactly CLK_DIV cycles, counted by cyc_cnt 0..CLK_DIV-1.
  - IDLE: tx_o=1. If !empty: pop head into shift register, go to START, cyc_cnt=0.
  - START: tx_o=0 for CLK_DIV cycles, then DATA with bit_cnt=0.
  - DATA: tx_o=shift[0], LSB first. After each CLK_DIV cycles, shift right and bit_cnt++. After bit 7, go to STOP.
  - STOP: tx_o=1 for CLK_DIV cycles. At the end of STOP: if !empty, pop and go directly to START (no idle gap); else go to IDLE.
- Frame length: 10*CLK_DIV cycles. busy = (state != IDLE).
- Latency: a TXDATA write sampled at edge N into an empty FIFO while IDLE has:
  - FIFO non-empty after edge N;
  - pop at edge N+1;
  - tx_o low from edge N+1.
- tx_o is driven from a register; no glitches.

Test Plan:
- Reset/idle: assert rst_i mid-cycle, release -> tx_o=1, ack_o=0, rdata_o=0; STATUS read returns 0x2 (empty).
- Single byte, CLK_DIV=4: write 0x0=0x000000A5 -> ack_o one cycle later; tx_o low from the next edge for 4 cycles; then bits 1,0,1,0,0,1,0,1, 4 cycles each; then high for 4 cycles. STATUS busy=1 during the frame and 0x2 after.
- Back-to-back: write 0x41, 0x42, 0x43 on consecutive cycles -> three contiguous frames totalling 120 cycles at CLK_DIV=4, no idle gap, bytes in order.
- Overflow, FIFO_DEPTH=8: 10 consecutive writes during the first frame -> the first byte is popped, 8 are queued, the 10th is dropped. STATUS shows full=1, ovf=1 (0xD, with busy). Write 0x8=1 -> ovf=0. Exactly 9 frames are transmitted.
- Bus decode: read 0x0, 0x8, 0xC -> rdata_o=0 with ack. Write 0xC=0xFF -> no FIFO change. Write 0x8=0 -> ovf unchanged.
- Reset mid-frame: assert rst_i during DATA with 3 bytes queued -> tx_o=1 immediately; after release STATUS=0x2 and no further frames.
